spi_frame_engine: RTL and testbench

Parametrised SPI slave frame engine between the Raspberry Pi SPI link and Interface0's internal command/data logic. It generalises the fixed 16-bit command exchange to a configurable frame width. It buffers outbound and inbound frames in FIFOs so the Pi can stream several words per ZX cycle without loss. It also flags malformed frames, TX underrun and RX overrun. All logic runs on PI_MASTER_CLK and oversamples the SPI pins.

---
 rtl/spi_frame_engine_pkg.sv | 17 +
 rtl/spi_frame_engine_sync_fifo.sv | 56 +++++
 rtl/spi_frame_engine.sv | 162 ++++++++++++++++
 tb/tb_spi_frame_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_engine_pkg.sv
// Shared types and constants for the SPI slave frame engine.
// EMPTY_CMD is the frame type shifted out when the host has nothing queued.
package spi_frame_engine_pkg;

  localparam logic [15:0] EMPTY_CMD = 16'hC3A5;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_READY     = 2'd1,
    ST_XFER      = 2'd2
  } state_e;

  function automatic int sat_inc(input int value, input int limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

endpackage

// File: rtl/spi_frame_engine_sync_fifo.sv
// Single-clock FIFO with registered count and first-word-fall-through output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spi_frame_engine_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_engine.sv
// SPI mode-0 slave frame engine: oversampled pins, TX/RX word FIFOs and
// malformed-frame / underrun / overrun pulses, all in the PI_MASTER_CLK domain.
module spi_frame_engine
  import spi_frame_engine_pkg::*;
#(
  parameter int                 FRAME_W   = 16,
  parameter int                 TX_DEPTH  = 4,
  parameter int                 RX_DEPTH  = 4,
  parameter logic [FRAME_W-1:0] IDLE_WORD = FRAME_W'(EMPTY_CMD)
) (
  input  logic               PI_MASTER_CLK,
  input  logic               PI_RESET_n,
  input  logic               SPI_CLK,
  input  logic               SPI_CS_n,
  input  logic               SPI_MOSI,
  output logic               SPI_MISO,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               tx_underrun,
  output logic               rx_overrun
);

  localparam int CNT_W = $clog2(FRAME_W + 2);

  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_cs_meta, r_cs_sync, r_cs_prev;
  logic r_mosi_meta, r_mosi_sync;

  state_e             r_state;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [FRAME_W-1:0] r_tx_shift;
  logic [FRAME_W-1:0] r_rx_shift;
  logic [FRAME_W-1:0] r_rx_word;
  logic               r_rx_push;
  logic               r_miso;
  logic               r_frame_err;
  logic               r_tx_underrun;
  logic               r_rx_overrun;

  logic               w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic               w_tx_pop;
  logic [FRAME_W-1:0] w_tx_head;
  logic               w_tx_full, w_tx_empty;
  logic               w_rx_full, w_rx_empty;

  assign w_sck_rise = r_sck_sync & ~r_sck_prev;
  assign w_sck_fall = ~r_sck_sync & r_sck_prev;
  assign w_cs_rise  = r_cs_sync & ~r_cs_prev;
  assign w_cs_fall  = ~r_cs_sync & r_cs_prev;
  assign w_tx_pop   = (r_state == ST_READY) & w_cs_fall;

  assign SPI_MISO    = r_miso;
  assign tx_ready    = ~w_tx_full;
  assign rx_valid    = ~w_rx_empty;
  assign frame_err   = r_frame_err;
  assign tx_underrun = r_tx_underrun;
  assign rx_overrun  = r_rx_overrun;

  spi_frame_engine_sync_fifo #(.WIDTH(FRAME_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (PI_MASTER_CLK),
    .i_rst_n (PI_RESET_n),
    .i_push  (tx_valid),
    .i_din   (tx_data),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  spi_frame_engine_sync_fifo #(.WIDTH(FRAME_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (PI_MASTER_CLK),
    .i_rst_n (PI_RESET_n),
    .i_push  (r_rx_push),
    .i_din   (r_rx_word),
    .i_pop   (rx_ready),
    .o_dout  (rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Pin synchronisers; CS_n resets low so WAIT_IDLE must see a real high level.
  always_ff @(posedge PI_MASTER_CLK or negedge PI_RESET_n) begin
    if (!PI_RESET_n) begin
      {r_sck_meta, r_sck_sync, r_sck_prev} <= 3'b000;
      {r_cs_meta, r_cs_sync, r_cs_prev}    <= 3'b000;
      {r_mosi_meta, r_mosi_sync}           <= 2'b00;
    end else begin
      {r_sck_meta, r_sck_sync, r_sck_prev} <= {SPI_CLK, r_sck_meta, r_sck_sync};
      {r_cs_meta, r_cs_sync, r_cs_prev}    <= {SPI_CS_n, r_cs_meta, r_cs_sync};
      {r_mosi_meta, r_mosi_sync}           <= {SPI_MOSI, r_mosi_meta};
    end
  end

  // Frame FSM, shift registers and event pulses.
  always_ff @(posedge PI_MASTER_CLK or negedge PI_RESET_n) begin
    if (!PI_RESET_n) begin
      r_state       <= ST_WAIT_IDLE;
      r_bitcnt      <= {CNT_W{1'b0}};
      r_tx_shift    <= {FRAME_W{1'b0}};
      r_rx_shift    <= {FRAME_W{1'b0}};
      r_rx_word     <= {FRAME_W{1'b0}};
      r_rx_push     <= 1'b0;
      r_miso        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      r_rx_push     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= r_rx_push & w_rx_full & ~rx_ready;
      case (r_state)
        ST_WAIT_IDLE: begin
          r_miso <= 1'b0;
          if (r_cs_sync) r_state <= ST_READY;
        end
        ST_READY: begin
          if (w_cs_fall) begin
            r_state  <= ST_XFER;
            r_bitcnt <= {CNT_W{1'b0}};
            if (!w_tx_empty) begin
              r_tx_shift <= w_tx_head;
              r_miso     <= w_tx_head[FRAME_W-1];
            end else begin
              r_tx_shift    <= IDLE_WORD;
              r_miso        <= IDLE_WORD[FRAME_W-1];
              r_tx_underrun <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (w_cs_rise) begin
            r_state <= ST_READY;
            r_miso  <= 1'b0;
            if (r_bitcnt == CNT_W'(FRAME_W)) begin
              r_rx_push <= 1'b1;
              r_rx_word <= r_rx_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sck_rise) begin
            r_rx_shift <= {r_rx_shift[FRAME_W-2:0], r_mosi_sync};
            r_bitcnt   <= CNT_W'(sat_inc(int'(r_bitcnt), FRAME_W + 1));
          end else if (w_sck_fall) begin
            r_tx_shift <= {r_tx_shift[FRAME_W-2:0], 1'b0};
            r_miso     <= r_tx_shift[FRAME_W-2];
          end
        end
        default: begin
          r_state <= ST_WAIT_IDLE;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_engine.sv
// Scoreboard bench for spi_frame_engine: a 16-bit and an 8-bit instance share
// the SPI pins through a select, with monitors checking MISO words and RX pops.
module tb_spi_frame_engine;

  localparam logic [15:0] IDLE16 = 16'hC3A5;
  localparam logic [7:0]  IDLE8  = 8'h96;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, cs_n, mosi, sel;
  logic [15:0] tx_data;
  logic        tx_valid, rx_ready;

  logic        miso16, tx_ready16, rx_valid16, ferr16, und16, ovr16;
  logic [15:0] rx_data16;
  logic        miso8, tx_ready8, rx_valid8, ferr8, und8, ovr8;
  logic [7:0]  rx_data8;

  logic        cs16, sck16, cs8, sck8;
  logic        cur_miso, cur_tx_ready, cur_rx_valid, cur_ferr, cur_und, cur_ovr;
  logic [31:0] cur_rx_data;

  int          n_chk = 0;
  int          n_fail = 0;
  int          fw = 16;
  logic [31:0] mask = 32'h0000_FFFF;
  logic [31:0] idle;
  logic [31:0] exp_rx[$];
  logic [31:0] exp_miso[$];
  int          cnt_err = 0, cnt_und = 0, cnt_ovr = 0;

  always #5 clk = ~clk;

  assign cs16  = sel ? 1'b1 : cs_n;
  assign sck16 = sel ? 1'b0 : sck;
  assign cs8   = sel ? cs_n : 1'b1;
  assign sck8  = sel ? sck : 1'b0;

  assign cur_miso     = sel ? miso8 : miso16;
  assign cur_tx_ready = sel ? tx_ready8 : tx_ready16;
  assign cur_rx_valid = sel ? rx_valid8 : rx_valid16;
  assign cur_rx_data  = sel ? {24'h0, rx_data8} : {16'h0, rx_data16};
  assign cur_ferr     = sel ? ferr8 : ferr16;
  assign cur_und      = sel ? und8 : und16;
  assign cur_ovr      = sel ? ovr8 : ovr16;

  spi_frame_engine #(.FRAME_W(16), .TX_DEPTH(4), .RX_DEPTH(4), .IDLE_WORD(IDLE16)) dut16 (
    .PI_MASTER_CLK (clk),
    .PI_RESET_n    (rst_n),
    .SPI_CLK       (sck16),
    .SPI_CS_n      (cs16),
    .SPI_MOSI      (mosi),
    .SPI_MISO      (miso16),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid & ~sel),
    .tx_ready      (tx_ready16),
    .rx_data       (rx_data16),
    .rx_valid      (rx_valid16),
    .rx_ready      (rx_ready & ~sel),
    .frame_err     (ferr16),
    .tx_underrun   (und16),
    .rx_overrun    (ovr16)
  );

  spi_frame_engine #(.FRAME_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .IDLE_WORD(IDLE8)) dut8 (
    .PI_MASTER_CLK (clk),
    .PI_RESET_n    (rst_n),
    .SPI_CLK       (sck8),
    .SPI_CS_n      (cs8),
    .SPI_MOSI      (mosi),
    .SPI_MISO      (miso8),
    .tx_data       (tx_data[7:0]),
    .tx_valid      (tx_valid & sel),
    .tx_ready      (tx_ready8),
    .rx_data       (rx_data8),
    .rx_valid      (rx_valid8),
    .rx_ready      (rx_ready & sel),
    .frame_err     (ferr8),
    .tx_underrun   (und8),
    .rx_overrun    (ovr8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (FRAME_W=%0d): got %0h expected %0h", name, fw, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RX pop monitor and pulse counters.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cur_ferr) cnt_err++;
      if (cur_und)  cnt_und++;
      if (cur_ovr)  cnt_ovr++;
      if (cur_rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_unexpected (FRAME_W=%0d): got %0h expected no word", fw, cur_rx_data);
        end else begin
          check("rx_data", cur_rx_data, exp_rx.pop_front());
        end
      end
    end
  end

  // MISO monitor: collects bits on SCK rise, compares complete frames at CS_n rise.
  logic        m_cs_prev = 1'b1;
  logic        m_sck_prev = 1'b0;
  logic [31:0] m_acc = 32'h0;
  int          m_nb = 0;
  always @(sck or cs_n) begin
    if (cs_n !== m_cs_prev) begin
      if (cs_n === 1'b0) begin
        m_acc = 32'h0;
        m_nb  = 0;
      end else if (m_nb == fw && exp_miso.size() > 0) begin
        check("miso_word", m_acc & mask, exp_miso.pop_front());
      end
      m_cs_prev = cs_n;
    end else if (sck === 1'b1 && m_sck_prev === 1'b0 && cs_n === 1'b0) begin
      m_acc = {m_acc[30:0], cur_miso};
      m_nb++;
    end
    m_sck_prev = sck;
  end

  task automatic frame(input logic [31:0] w, input int nbits, input bit chk_txr);
    cs_n = 1'b0;
    wait_clk(8);
    if (chk_txr) check("tx_ready_after_pop", {31'h0, cur_tx_ready}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[nbits-1-i];
      wait_clk(4);
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
      wait_clk(4);
    end
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] miso_exp, input bit chk_txr);
    exp_miso.push_back(miso_exp & mask);
    exp_rx.push_back(w & mask);
    frame(w, fw, chk_txr);
  endtask

  task automatic push_tx(input logic [15:0] d);
    int k = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!cur_tx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) check("tx_push_timeout", {31'h0, cur_tx_ready}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic run_suite(input bit s);
    int e0, u0, o0;
    sel      = s;
    fw       = s ? 8 : 16;
    mask     = (32'd1 << fw) - 32'd1;
    idle     = s ? {24'h0, IDLE8} : {16'h0, IDLE16};
    rx_ready = 1'b1;
    wait_clk(4);

    // Queued word out, clean word in, no pulses.
    e0 = cnt_err; u0 = cnt_und; o0 = cnt_ovr;
    push_tx(16'hA55A);
    send(32'h1234, 32'hA55A, 1'b0);
    check("t1_no_frame_err", cnt_err - e0, 32'd0);
    check("t1_no_underrun", cnt_und - u0, 32'd0);
    check("t1_no_overrun", cnt_ovr - o0, 32'd0);

    // Empty TX FIFO sends the idle word once.
    u0 = cnt_und;
    send(32'hFFFF, idle, 1'b0);
    check("t2_underrun_count", cnt_und - u0, 32'd1);

    // Short and long frames are flagged and dropped.
    e0 = cnt_err;
    frame(32'h0ABC, fw - 4, 1'b0);
    frame(32'h1FFFF, fw + 1, 1'b0);
    check("t3_frame_err_count", cnt_err - e0, 32'd2);
    check("t3_rx_valid_low", {31'h0, cur_rx_valid}, 32'd0);
    send(32'h0066, idle, 1'b0);

    // RX FIFO overrun on the fifth unread frame.
    rx_ready = 1'b0;
    o0 = cnt_ovr;
    for (int i = 1; i <= 4; i++) send(32'(i), idle, 1'b0);
    check("t4_no_overrun_yet", cnt_ovr - o0, 32'd0);
    exp_miso.push_back(idle & mask);
    frame(32'h0005, fw, 1'b0);
    check("t4_overrun_count", cnt_ovr - o0, 32'd1);
    check("t4_rx_valid_full", {31'h0, cur_rx_valid}, 32'd1);
    rx_ready = 1'b1;
    wait_clk(10);
    check("t4_rx_drained", {31'h0, cur_rx_valid}, 32'd0);
    check("t4_rx_all_popped", 32'(exp_rx.size()), 32'd0);

    // TX FIFO fill, back-pressure and in-order drain.
    for (int i = 0; i < 4; i++) push_tx(16'h0010 + 16'(i));
    check("t5_tx_ready_full", {31'h0, cur_tx_ready}, 32'd0);
    for (int i = 0; i < 4; i++) send(32'h00A0 + 32'(i), 32'h0010 + 32'(i), i == 0);

    // Reset mid-frame discards the frame silently.
    e0 = cnt_err;
    cs_n = 1'b0;
    mosi = 1'b1;
    wait_clk(8);
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
      wait_clk(8);
    end
    rst_n = 1'b0;
    wait_clk(3);
    check("t6_miso_in_reset", {31'h0, cur_miso}, 32'd0);
    check("t6_tx_ready_in_reset", {31'h0, cur_tx_ready}, 32'd1);
    rst_n = 1'b1;
    wait_clk(10);
    check("t6_miso_after_reset", {31'h0, cur_miso}, 32'd0);
    cs_n = 1'b1;
    wait_clk(12);
    check("t6_no_frame_err", cnt_err - e0, 32'd0);
    check("t6_no_push", {31'h0, cur_rx_valid}, 32'd0);
    push_tx(16'h7E7E);
    send(32'hBEEF, 32'h7E7E, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    sck      = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    sel      = 1'b0;
    tx_data  = 16'h0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    wait_clk(4);
    check("rst_miso16", {31'h0, miso16}, 32'd0);
    check("rst_tx_ready16", {31'h0, tx_ready16}, 32'd1);
    check("rst_rx_valid16", {31'h0, rx_valid16}, 32'd0);
    check("rst_rx_data16", {16'h0, rx_data16}, 32'd0);
    check("rst_pulses16", {29'h0, ferr16, und16, ovr16}, 32'd0);
    check("rst_miso8", {31'h0, miso8}, 32'd0);
    check("rst_tx_ready8", {31'h0, tx_ready8}, 32'd1);
    check("rst_rx_valid8", {31'h0, rx_valid8}, 32'd0);
    check("rst_rx_data8", {24'h0, rx_data8}, 32'd0);
    rst_n = 1'b1;
    wait_clk(8);

    run_suite(1'b0);
    run_suite(1'b1);

    wait_clk(10);
    check("end_miso_queue_empty", 32'(exp_miso.size()), 32'd0);
    check("end_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
